// File: rtl/id_ex_pipeline_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg_if
// Description : Decode-to-execute bus: id_* fields and stall/flush in,
//               packed PR2 and hazard_stall out.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_pipeline_reg_if #(
    parameter int PR_W = 500
);
    logic            stall_in;
    logic            flush;
    logic            id_valid;
    logic [63:0]     id_pc;
    logic [31:0]     id_instr;
    logic            id_alusrc;
    logic            id_memtoreg;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic            id_branch;
    logic            id_uncondbranch;
    logic [1:0]      id_aluop;
    logic [63:0]     id_data1;
    logic [63:0]     id_data2;
    logic [63:0]     id_seout;
    logic [4:0]      id_rd;
    logic [4:0]      id_rn;
    logic [4:0]      id_rm;
    logic [PR_W-1:0] PR2;
    logic            hazard_stall;

    modport master (
        output stall_in, flush, id_valid, id_pc, id_instr, id_alusrc, id_memtoreg,
               id_regwrite, id_memread, id_memwrite, id_branch, id_uncondbranch,
               id_aluop, id_data1, id_data2, id_seout, id_rd, id_rn, id_rm,
        input  PR2, hazard_stall
    );

    modport slave (
        input  stall_in, flush, id_valid, id_pc, id_instr, id_alusrc, id_memtoreg,
               id_regwrite, id_memread, id_memwrite, id_branch, id_uncondbranch,
               id_aluop, id_data1, id_data2, id_seout, id_rd, id_rn, id_rm,
        output PR2, hazard_stall
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg
// Description : ID/EX pipeline register with load-use hazard detection and
//               bubble insertion. Define ID_EX_PERF_CNT_EN to add the
//               bubble_count hazard-bubble counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_reg #(
    parameter int XZR_REG = 31,
    parameter int PR_W    = 500
) (
    input  wire logic         clk,
    input  wire logic         reset,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       bubble_count,
`endif
    id_ex_pipeline_reg_if.slave bus
);

    localparam logic [4:0] c_xzr = 5'(XZR_REG);

    logic [PR_W-1:0] r_pr2;
    logic [PR_W-1:0] w_load;
    logic [PR_W-1:0] w_bubble;
    logic [7:0]      w_ctrl;
    logic            w_unc;
    logic            w_hazard;

    // Control bits of a non-valid decode slot are forced to zero.
    assign w_ctrl = bus.id_valid ? {bus.id_aluop, bus.id_branch, bus.id_memwrite,
                                    bus.id_memread, bus.id_regwrite,
                                    bus.id_memtoreg, bus.id_alusrc} : 8'h00;
    assign w_unc  = bus.id_valid & bus.id_uncondbranch;

    assign w_load = {{(PR_W-313){1'b0}}, w_unc, bus.id_valid,
                     bus.id_rm, bus.id_rn, bus.id_rd,
                     bus.id_seout, bus.id_data2, bus.id_data1,
                     w_ctrl, bus.id_instr, bus.id_pc};

    always_comb begin
        w_bubble          = r_pr2;
        w_bubble[103:96]  = 8'h00;
        w_bubble[312:311] = 2'b00;
    end

    // Load in EX whose destination feeds either source of the decoding instruction.
    assign w_hazard = r_pr2[311] & r_pr2[99] & bus.id_valid
                    & (r_pr2[300:296] != c_xzr)
                    & ((r_pr2[300:296] == bus.id_rn) | (r_pr2[300:296] == bus.id_rm));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pr2 <= '0;
        end else if (bus.flush) begin
            r_pr2 <= w_bubble;
        end else if (bus.stall_in) begin
            r_pr2 <= r_pr2;
        end else if (w_hazard) begin
            r_pr2 <= w_bubble;
        end else begin
            r_pr2 <= w_load;
        end
    end

    assign bus.PR2          = r_pr2;
    assign bus.hazard_stall = w_hazard;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_count;

    // Only hazard bubbles are counted; flush bubbles are excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_count <= 32'h0;
        end else if (!bus.flush && !bus.stall_in && w_hazard) begin
            r_bubble_count <= r_bubble_count + 32'h1;
        end
    end

    assign bubble_count = r_bubble_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipeline_reg
// Description : Self-checking bench for id_ex_pipeline_reg (vector table plus
//               hand-written reset / hazard sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipeline_reg;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    id_ex_pipeline_reg_if #(.PR_W(500)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_count;
`endif

    id_ex_pipeline_reg #(.XZR_REG(31), .PR_W(500)) dut (
        .clk          (clk),
        .reset        (rst),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_count (bubble_count),
`endif
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [63:0] pc;
        logic [7:0]  ctrl;   // {aluop, branch, memwrite, memread, regwrite, memtoreg, alusrc}
        logic        unc;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        exp_hz;
        logic        chk_pc;
        logic [63:0] exp_pc;
        logic [7:0]  exp_ctrl;
        logic        exp_v;
        logic        exp_unc;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic st, input logic fl, input logic v,
                                input logic [63:0] pc, input logic [7:0] ctrl,
                                input logic unc, input logic [4:0] rd,
                                input logic [4:0] rn, input logic [4:0] rm,
                                input logic hz, input logic cpc,
                                input logic [63:0] epc, input logic [7:0] ectrl,
                                input logic ev, input logic eunc);
        vec_t r;
        r.stall = st; r.flush = fl; r.valid = v; r.pc = pc; r.ctrl = ctrl;
        r.unc = unc; r.rd = rd; r.rn = rn; r.rm = rm; r.exp_hz = hz;
        r.chk_pc = cpc; r.exp_pc = epc; r.exp_ctrl = ectrl; r.exp_v = ev;
        r.exp_unc = eunc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic v,
                         input logic [63:0] pc, input logic [7:0] ctrl,
                         input logic unc, input logic [4:0] rd,
                         input logic [4:0] rn, input logic [4:0] rm);
        bus.stall_in        = st;
        bus.flush           = fl;
        bus.id_valid        = v;
        bus.id_pc           = pc;
        bus.id_instr        = pc[31:0] ^ 32'hF8400000;
        {bus.id_aluop, bus.id_branch, bus.id_memwrite, bus.id_memread,
         bus.id_regwrite, bus.id_memtoreg, bus.id_alusrc} = ctrl;
        bus.id_uncondbranch = unc;
        bus.id_data1        = pc + 64'h1000;
        bus.id_data2        = pc + 64'h2000;
        bus.id_seout        = pc + 64'h3000;
        bus.id_rd           = rd;
        bus.id_rn           = rn;
        bus.id_rm           = rm;
    endtask

    initial begin
        logic [499:0] snap;
        n_cmp = 0;
        n_err = 0;

        // LDUR=0F, ADD=84, STUR=11
        vecs[0]  = mk(0,0,1,64'h44,8'h0F,0, 3, 1,31, 0,1,64'h44,8'h0F,1,0);
        vecs[1]  = mk(0,0,1,64'h48,8'h84,0, 5, 2, 3, 1,0,64'h0, 8'h00,0,0);
        vecs[2]  = mk(0,0,1,64'h48,8'h84,0, 5, 2, 3, 0,1,64'h48,8'h84,1,0);
        vecs[3]  = mk(0,0,1,64'h4C,8'h0F,0,31, 5,31, 0,1,64'h4C,8'h0F,1,0);
        vecs[4]  = mk(0,0,1,64'h50,8'h84,0, 6,31,31, 0,1,64'h50,8'h84,1,0);
        vecs[5]  = mk(0,0,0,64'h54,8'h84,1, 7, 1, 2, 0,1,64'h54,8'h00,0,0);
        vecs[6]  = mk(0,0,1,64'h58,8'h00,1,31,31,31, 0,1,64'h58,8'h00,1,1);
        vecs[7]  = mk(0,0,1,64'h5C,8'h0F,0, 9, 1, 2, 0,1,64'h5C,8'h0F,1,0);
        vecs[8]  = mk(1,0,1,64'h60,8'h84,0,10, 9, 2, 1,1,64'h5C,8'h0F,1,0);
        vecs[9]  = mk(1,0,1,64'h64,8'h11,0,11, 9, 3, 1,1,64'h5C,8'h0F,1,0);
        vecs[10] = mk(1,0,1,64'h68,8'h84,1,12, 4, 9, 1,1,64'h5C,8'h0F,1,0);
        vecs[11] = mk(1,1,1,64'h6C,8'h84,0,13, 9, 9, 1,0,64'h0, 8'h00,0,0);
        vecs[12] = mk(0,0,1,64'h70,8'h84,0,11, 9, 9, 0,1,64'h70,8'h84,1,0);
        vecs[13] = mk(0,1,1,64'h74,8'h11,0, 3, 4, 5, 0,0,64'h0, 8'h00,0,0);
        vecs[14] = mk(0,0,1,64'h78,8'h11,0, 3, 4, 5, 0,1,64'h78,8'h11,1,0);
        vecs[15] = mk(0,0,1,64'h7C,8'h0F,0,12, 1, 2, 0,1,64'h7C,8'h0F,1,0);
        vecs[16] = mk(0,0,1,64'h80,8'h84,0,14, 1,12, 1,0,64'h0, 8'h00,0,0);
        vecs[17] = mk(0,0,1,64'h80,8'h84,0,14, 1,12, 0,1,64'h80,8'h84,1,0);

        // Reset state
        rst = 1'b1;
        drive(0,0,0,64'h0,8'h00,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pr2_zero", 64'(|bus.PR2), 64'h0);
        chk("reset_hazard", 64'(bus.hazard_stall), 64'h0);
`ifdef ID_EX_PERF_CNT_EN
        chk("reset_count", 64'(bubble_count), 64'h0);
`endif
        rst = 1'b0;

        // Basic load
        drive(0,0,1,64'h40,8'h01,0,1,2,4);
        bus.id_data2 = 64'h5;
        bus.id_seout = 64'h10;
        @(posedge clk); #1;
        chk("load_pc", bus.PR2[63:0], 64'h40);
        chk("load_data2", bus.PR2[231:168], 64'h5);
        chk("load_seout", bus.PR2[295:232], 64'h10);
        chk("load_alusrc", 64'(bus.PR2[96]), 64'h1);
        chk("load_valid", 64'(bus.PR2[311]), 64'h1);
        chk("load_upper_zero", 64'(|bus.PR2[499:313]), 64'h0);
        chk("load_rd_rn_rm", 64'(bus.PR2[310:296]), 64'({5'd4, 5'd2, 5'd1}));

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].pc,
                  vecs[i].ctrl, vecs[i].unc, vecs[i].rd, vecs[i].rn, vecs[i].rm);
            #1;
            chk($sformatf("v%0d_hazard", i), 64'(bus.hazard_stall), 64'(vecs[i].exp_hz));
            snap = bus.PR2;
            @(posedge clk); #1;
            if (vecs[i].chk_pc)
                chk($sformatf("v%0d_pc", i), bus.PR2[63:0], vecs[i].exp_pc);
            chk($sformatf("v%0d_ctrl", i), 64'(bus.PR2[103:96]), 64'(vecs[i].exp_ctrl));
            chk($sformatf("v%0d_valid", i), 64'(bus.PR2[311]), 64'(vecs[i].exp_v));
            chk($sformatf("v%0d_uncond", i), 64'(bus.PR2[312]), 64'(vecs[i].exp_unc));
            if (vecs[i].stall && !vecs[i].flush)
                chk($sformatf("v%0d_hold_all", i), 64'(bus.PR2 != snap), 64'h0);
        end

`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_count_two", 64'(bubble_count), 64'h2);
`endif

        // Reset asserted while a load-use hazard is active
        drive(0,0,1,64'h90,8'h0F,0,3,1,2);
        @(posedge clk); #1;
        drive(0,0,1,64'h94,8'h84,0,4,1,3);
        #1;
        chk("pre_reset_hazard", 64'(bus.hazard_stall), 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_hazard_reset_pr2", 64'(|bus.PR2), 64'h0);
        chk("post_reset_hazard", 64'(bus.hazard_stall), 64'h0);
`ifdef ID_EX_PERF_CNT_EN
        chk("post_reset_count", 64'(bubble_count), 64'h0);
`endif
        @(posedge clk); #1;
        chk("post_reset_load_pc", bus.PR2[63:0], 64'h94);
        chk("post_reset_load_valid", 64'(bus.PR2[311]), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
ID/EX pipeline register. Captures decoded operands, the sign-extended immediate and control bits from the decode stage, and drives the 500-bit PR2 bus consumed by the execute stage (ALU source select, ALU, branch adder). It also contains the load-use hazard detector and inserts bubbles on stall or flush.

Parameters:
XZR_REG, 31, register index that never causes a hazard (zero register)
PR_W, 500, width of PR2 bus

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall_in  input  1  downstream stall; hold PR2 unchanged
flush  input  1  branch-taken squash; load bubble
id_valid  input  1  decode stage holds a real instruction
id_pc  input  64  instruction PC
id_instr  input  32  raw instruction
id_alusrc  input  1  0 = Data2, 1 = SEout
id_memtoreg  input  1  writeback select
id_regwrite  input  1  register write enable
id_memread  input  1  load
id_memwrite  input  1  store
id_branch  input  1  conditional branch (CBZ)
id_uncondbranch  input  1  B
id_aluop  input  2  ALU op class
id_data1  input  64  register file read port 1
id_data2  input  64  register file read port 2
id_seout  input  64  sign-extended immediate
id_rd  input  5  destination register
id_rn  input  5  source register 1
id_rm  input  5  source register 2
PR2  output  500  packed ID/EX register
hazard_stall  output  1  load-use hazard; IF/ID and PC must hold

Behaviour:
- PR2 layout (fixed):
  - [63:0] PC; [95:64] instr
  - [96] ALUSrc; [97] MemtoReg; [98] RegWrite; [99] MemRead; [100] MemWrite; [101] Branch; [103:102] ALUOp
  - [167:104] Data1; [231:168] Data2; [295:232] SEout
  - [300:296] Rd; [305:301] Rn; [310:306] Rm
  - [311] valid; [312] UncondBranch; [499:313] always 0
- Bubble = bits [103:96], [312] and [311] cleared. Datapath fields may be left as loaded, but the bench checks only the control and valid bits of a bubble.
- hazard_stall is combinational: PR2[311] & PR2[99] & id_valid & (PR2[300:296] != XZR_REG) & (PR2[300:296] == id_rn | PR2[300:296] == id_rm).
- Update priority, evaluated at each rising clk:
  - reset: PR2 <= 0.
  - flush: bubble.
  - stall_in: hold all 500 bits.
  - hazard_stall: bubble, which inserts one cycle of delay.
  - otherwise: load all id_* fields, valid <= id_valid. When id_valid = 0, control bits load as 0.
- Latency: 1 cycle from id_* to PR2.
- Simultaneous events:
  - flush overrides both stall_in and hazard.
  - stall_in with hazard: hold, so no double bubble. hazard_stall stays high and decode stays frozen.
  - After a hazard bubble, PR2[311] = 0, so hazard_stall deasserts and the dependent instruction loads on the next edge.
- Reset asserted mid-stall or mid-hazard clears everything on that edge; hazard_stall = 0 on the following cycle.
- No X on PR2 after the first reset edge.

Optional Feature:
ID_EX_PERF_CNT_EN: adds output bubble_count [31:0].
- Increments by 1 on each edge where a hazard bubble is inserted and reset is low. Flush bubbles are not counted.
- Cleared by reset; wraps from 0xFFFFFFFF to 0.
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then load id_pc=0x40, id_data2=0x5, id_seout=0x10, id_alusrc=1, id_valid=1 -> next cycle PR2[63:0]=0x40, PR2[231:168]=0x5, PR2[295:232]=0x10, PR2[96]=1, PR2[311]=1, PR2[499:313]=0.
- LDUR X3 in PR2 (MemRead=1, Rd=3), incoming id_rm=3 -> hazard_stall=1. Next edge loads a bubble (PR2[103:96]=0, [311]=0). The following edge loads the held instruction, and hazard_stall=0.
- LDUR XZR (Rd=31) followed by use of rn=31 -> hazard_stall=0, no bubble.
- stall_in=1 for 3 cycles while id_* changes -> PR2 constant across all 3 edges.
- flush=1 together with stall_in=1 and an active hazard -> bubble loaded; RegWrite, MemWrite and valid are 0.
- With ID_EX_PERF_CNT_EN: 2 load-use hazards plus 1 flush -> bubble_count=2. Reset -> 0.
